temp_avg_monitor: RTL and testbench

Downstream consumer of the 9-bit signed temperature word from the pulse-duration-to-temperature converter. Keeps a sliding-window moving average over the last 2^LOG2_DEPTH measurements and presents it on a valid/ready output port. Drives an over-temperature alarm with hysteresis. Feeds the readout/control logic at chip top.

---
 rtl/temp_avg_pkg.sv | 24 ++
 rtl/temp_avg_ringbuf.sv | 43 ++++
 rtl/temp_avg_monitor.sv | 150 +++++++++++++++
 tb/tb_temp_avg_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/temp_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : temp_avg_pkg
// Brief   : Shared types and constants for the temperature averaging monitor.
// Revision: 1.0 - initial release
// ============================================================================
package temp_avg_pkg;

  // Native width of the converter's temperature word.
  localparam int TEMP_WIDTH = 9;

  typedef logic signed [TEMP_WIDTH-1:0] temp_t;

  // Extremes of the 9-bit signed range; used as min/max tracker reset values.
  localparam int TEMP_MAX = 255;
  localparam int TEMP_MIN = -256;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } mon_state_t;

endpackage
`default_nettype wire

// File: rtl/temp_avg_ringbuf.sv
`default_nettype none
// ============================================================================
// Module  : temp_avg_ringbuf
// Brief   : Circular sample buffer with internal write pointer. The entry at
//           the write pointer (the one about to be overwritten) is presented
//           combinationally so the caller can subtract it from a running sum.
// Revision: 1.0 - initial release
// ============================================================================
module temp_avg_ringbuf
  import temp_avg_pkg::*;
#(
  parameter int LOG2_DEPTH = 3,
  parameter int W          = TEMP_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic signed [W-1:0] wr_data,
  output logic signed [W-1:0] evicted
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic signed [W-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0]    wr_ptr;

  assign evicted = mem[wr_ptr];

  // Store the sample at the write pointer; pointer wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/temp_avg_monitor.sv
`default_nettype none
// ============================================================================
// Module  : temp_avg_monitor
// Brief   : Sliding-window moving average of the signed temperature word with
//           valid/ready output, sticky overrun flag and hysteresis alarm.
//           Optional min/max average tracking when TEMP_AVG_MINMAX_EN is
//           defined (adds minmax_clr, min_out, max_out).
// Revision: 1.0 - initial release
// ============================================================================
module temp_avg_monitor
  import temp_avg_pkg::*;
#(
  parameter int LOG2_DEPTH = 3,
  parameter int TEMP_W     = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [TEMP_W-1:0] temp_in,
  input  logic                     temp_valid,
  input  logic signed [TEMP_W-1:0] thr_hi,
  input  logic signed [TEMP_W-1:0] thr_lo,
`ifdef TEMP_AVG_MINMAX_EN
  input  logic                     minmax_clr,
  output logic signed [TEMP_W-1:0] min_out,
  output logic signed [TEMP_W-1:0] max_out,
`endif
  output logic signed [TEMP_W-1:0] avg_out,
  output logic                     avg_valid,
  input  logic                     avg_ready,
  output logic                     alarm,
  output logic                     overrun,
  output logic                     fill_done
);

  localparam int SUM_W = TEMP_W + LOG2_DEPTH;

  mon_state_t                state, state_next;
  logic [LOG2_DEPTH-1:0]     fill_cnt;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   sum_next;
  logic signed [SUM_W-1:0]   sum_shifted;
  logic signed [TEMP_W-1:0]  evicted_raw;
  logic signed [TEMP_W-1:0]  evicted;
  logic signed [TEMP_W-1:0]  avg_calc;
  logic                      new_result;
  logic                      last_fill;

  temp_avg_ringbuf #(
    .LOG2_DEPTH (LOG2_DEPTH),
    .W          (TEMP_W)
  ) u_ringbuf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (temp_valid),
    .wr_data (temp_in),
    .evicted (evicted_raw)
  );

  // The buffer is zeroed on reset, but gate explicitly so FILL never subtracts.
  assign evicted   = (state == RUN) ? evicted_raw : '0;
  assign last_fill = &fill_cnt;

  // Running-sum update and floor average (arithmetic shift floors toward -inf).
  always_comb begin
    sum_next    = sum
                + {{LOG2_DEPTH{temp_in[TEMP_W-1]}}, temp_in}
                - {{LOG2_DEPTH{evicted[TEMP_W-1]}}, evicted};
    sum_shifted = sum_next >>> LOG2_DEPTH;
    avg_calc    = sum_shifted[TEMP_W-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= FILL;
    else          state <= state_next;
  end

  // Next state: leave FILL on the sample that completes the window.
  always_comb begin
    state_next = state;
    if (state == FILL && temp_valid && last_fill) state_next = RUN;
  end

  // FSM outputs: result strobe and window-populated flag.
  always_comb begin
    new_result = 1'b0;
    fill_done  = 1'b0;
    case (state)
      FILL:    new_result = temp_valid && last_fill;
      RUN: begin
        new_result = temp_valid;
        fill_done  = 1'b1;
      end
      default: new_result = 1'b0;
    endcase
  end

  // Fill counter and running sum track every accepted sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_cnt <= '0;
      sum      <= '0;
    end else if (temp_valid) begin
      sum <= sum_next;
      if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Output port: new result overwrites, handshake clears, overrun is sticky.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avg_out   <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
      alarm     <= 1'b0;
    end else if (new_result) begin
      avg_out   <= avg_calc;
      avg_valid <= 1'b1;
      if (avg_valid && !avg_ready) overrun <= 1'b1;
      // Set has priority so an inverted threshold pair still raises the alarm.
      if (avg_calc >= thr_hi)      alarm <= 1'b1;
      else if (avg_calc <= thr_lo) alarm <= 1'b0;
    end else if (avg_ready) begin
      avg_valid <= 1'b0;
    end
  end

`ifdef TEMP_AVG_MINMAX_EN
  // Extreme-average tracking; a clear coinciding with a result loads it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      min_out <= TEMP_W'(TEMP_MAX);
      max_out <= TEMP_W'(TEMP_MIN);
    end else if (new_result) begin
      if (minmax_clr) begin
        min_out <= avg_calc;
        max_out <= avg_calc;
      end else begin
        if (avg_calc < min_out) min_out <= avg_calc;
        if (avg_calc > max_out) max_out <= avg_calc;
      end
    end else if (minmax_clr) begin
      min_out <= TEMP_W'(TEMP_MAX);
      max_out <= TEMP_W'(TEMP_MIN);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_temp_avg_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_temp_avg_monitor
// Brief   : Self-checking bench for temp_avg_monitor: directed scenarios then
//           randomized traffic against a queue-based window-average model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_temp_avg_monitor;

  localparam int LOG2_DEPTH = 3;
  localparam int TEMP_W     = 9;
  localparam int DEPTH      = 1 << LOG2_DEPTH;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic signed [TEMP_W-1:0] temp_in;
  logic                     temp_valid;
  logic signed [TEMP_W-1:0] thr_hi;
  logic signed [TEMP_W-1:0] thr_lo;
  logic signed [TEMP_W-1:0] avg_out;
  logic                     avg_valid;
  logic                     avg_ready;
  logic                     alarm;
  logic                     overrun;
  logic                     fill_done;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int   win[$];
  int   m_avg;
  logic m_valid, m_alarm, m_over, m_fill;

  temp_avg_monitor #(
    .LOG2_DEPTH (LOG2_DEPTH),
    .TEMP_W     (TEMP_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .alarm      (alarm),
    .overrun    (overrun),
    .fill_done  (fill_done)
  );

  always #5 clk = ~clk;

  // Mathematical floor of s / DEPTH.
  function automatic int fdiv(input int s);
    if (s >= 0) return s / DEPTH;
    return -((-s + DEPTH - 1) / DEPTH);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Model reacting to the inputs present at a rising edge.
  task automatic model_edge();
    int  s;
    int  r;
    bit  res;
    if (!reset_n) begin
      win.delete();
      m_valid = 1'b0;
      m_alarm = 1'b0;
      m_over  = 1'b0;
      m_avg   = 0;
    end else begin
      res = 1'b0;
      r   = 0;
      if (temp_valid) begin
        win.push_back(int'(temp_in));
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
          s = 0;
          foreach (win[i]) s += win[i];
          r   = fdiv(s);
          res = 1'b1;
        end
      end
      if (res) begin
        if (m_valid && !avg_ready) m_over = 1'b1;
        m_valid = 1'b1;
        m_avg   = r;
        if (r >= int'(thr_hi))      m_alarm = 1'b1;
        else if (r <= int'(thr_lo)) m_alarm = 1'b0;
      end else if (avg_ready) begin
        m_valid = 1'b0;
      end
    end
    m_fill = (win.size() == DEPTH);
  endtask

  // One clock: drive, let the edge happen, update the model, compare.
  task automatic cyc(input logic rn, input logic v, input int t, input logic rdy);
    reset_n    = rn;
    temp_valid = v;
    temp_in    = TEMP_W'(t);
    avg_ready  = rdy;
    @(posedge clk);
    model_edge();
    #1;
    chk("avg_out",   avg_out,   m_avg);
    chk("avg_valid", {31'd0, avg_valid}, {31'd0, m_valid});
    chk("alarm",     {31'd0, alarm},     {31'd0, m_alarm});
    chk("overrun",   {31'd0, overrun},   {31'd0, m_over});
    chk("fill_done", {31'd0, fill_done}, {31'd0, m_fill});
  endtask

  initial begin
    reset_n = 1'b0; temp_valid = 1'b0; temp_in = '0; avg_ready = 1'b1;
    thr_hi = 9'sd100; thr_lo = -9'sd100;

    // Reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_avg_out", avg_out, 0);
    chk("rst_valid",   {31'd0, avg_valid}, 0);
    chk("rst_fill",    {31'd0, fill_done}, 0);

    // Fill with 25: nothing before the eighth sample
    for (int i = 0; i < DEPTH - 1; i++) begin
      cyc(1, 1, 25, 1);
      chk("fill_no_valid", {31'd0, avg_valid}, 0);
    end
    cyc(1, 1, 25, 1);
    chk("fill_avg", avg_out, 25);
    chk("fill_valid", {31'd0, avg_valid}, 1);
    chk("fill_done", {31'd0, fill_done}, 1);
    cyc(1, 0, 0, 1);
    chk("valid_one_cycle", {31'd0, avg_valid}, 0);
    cyc(1, 1, 33, 1);
    chk("avg_26", avg_out, 26);

    // Floor rounding toward minus infinity
    cyc(0, 0, 0, 1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1, 1, 0, 1);
    cyc(1, 1, -1, 1);
    chk("floor_m1", avg_out, -1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, -3, 1);
    chk("avg_m3", avg_out, -3);

    // Alarm hysteresis: averages 79, 80, 75, 71, 70
    thr_hi = 9'sd80; thr_lo = 9'sd70;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 79, 1);
    chk("alm79", {31'd0, alarm}, 0);
    cyc(1, 1, 87, 1); chk("avg80", avg_out, 80); chk("alm80", {31'd0, alarm}, 1);
    cyc(1, 1, 39, 1); chk("avg75", avg_out, 75); chk("alm75", {31'd0, alarm}, 1);
    cyc(1, 1, 47, 1); chk("avg71", avg_out, 71); chk("alm71", {31'd0, alarm}, 1);
    cyc(1, 1, 71, 1); chk("avg70", avg_out, 70); chk("alm70", {31'd0, alarm}, 0);

    // Overrun: two results with consumer stalled
    cyc(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 40, 0);
    chk("ovr_first", avg_out, 40);
    cyc(1, 1, 48, 0);
    chk("ovr_avg41", avg_out, 41);
    chk("ovr_valid", {31'd0, avg_valid}, 1);
    chk("ovr_set", {31'd0, overrun}, 1);
    cyc(1, 0, 0, 1);
    chk("ovr_drain", {31'd0, avg_valid}, 0);
    chk("ovr_sticky", {31'd0, overrun}, 1);

    // Mid-operation reset discards partial window
    for (int i = 0; i < 5; i++) cyc(1, 1, 50, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 10, 1);
    chk("rst_avg10", avg_out, 10);
    chk("rst_alarm", {31'd0, alarm}, 0);
    chk("rst_ovr", {31'd0, overrun}, 0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        thr_hi = TEMP_W'(int'($urandom_range(0, 200)) - 100);
        thr_lo = TEMP_W'(int'($urandom_range(0, 200)) - 100);
      end
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 511)) - 256,
          ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
